// File: rtl/vadd_mem.sv
// Memory-side responder for the vector-add controller: A/B operand BRAMs, C result BRAM,
// two-stage read-add pipeline, host load/readback port. Optional macro VADD_SAT_EN selects saturating add.
module vadd_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              enr,
  input  logic              enw,
  input  logic              wea,
  output logic [DATA_W-1:0] sum,
  output logic              sum_vld,
  output logic [ADDR_W:0]   wr_cnt,
  output logic              ovf,
  input  logic              ld_en,
  input  logic              ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] rb_data
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [DATA_W-1:0] mem_c [DEPTH];

  logic [DATA_W-1:0] a_q, b_q, sum_q, sum_d, rb_q;
  logic [1:0]        vld_pipe_q;
  logic [ADDR_W:0]   wr_cnt_q;
  logic              ovf_q;
  logic [DATA_W:0]   add_full;

  // Writes of every array are suppressed while reset is asserted.
  logic a_we, b_we, c_we;
  assign a_we = ld_en & ~ld_sel & ~rst;
  assign b_we = ld_en &  ld_sel & ~rst;
  assign c_we = enw & wea & ~rst;

  always_ff @(posedge clk) if (a_we) mem_a[ld_addr] <= ld_data;
  always_ff @(posedge clk) if (b_we) mem_b[ld_addr] <= ld_data;
  always_ff @(posedge clk) if (c_we) mem_c[addr]    <= sum_q;

  assign add_full = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    sum_d = add_full[DATA_W-1:0];
`ifdef VADD_SAT_EN
    if (add_full[DATA_W]) sum_d = '1;
`endif
  end

  // Reads sample the arrays with nonblocking semantics, so a same-edge load is read-first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      vld_pipe_q <= '0;
      sum_q      <= '0;
      wr_cnt_q   <= '0;
      ovf_q      <= 1'b0;
      rb_q       <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], enr};
      if (enr) begin
        a_q <= mem_a[addr];
        b_q <= mem_b[addr];
      end
      if (vld_pipe_q[0]) sum_q <= sum_d;
      if (vld_pipe_q[0] && add_full[DATA_W]) ovf_q <= 1'b1;
      if (c_we && wr_cnt_q != CNT_MAX) wr_cnt_q <= wr_cnt_q + 1'b1;
      rb_q <= mem_c[ld_addr];
    end
  end

  assign sum     = sum_q;
  assign sum_vld = vld_pipe_q[1];
  assign wr_cnt  = wr_cnt_q;
  assign ovf     = ovf_q;
  assign rb_data = rb_q;
endmodule

// File: tb/tb_vadd_mem.sv
// Directed bench for vadd_mem: default-size instance plus a 4-deep instance for the write counter limit.
module tb_vadd_mem;
  logic        gclk = 1'b0;
  logic        rst;
  logic [9:0]  addr, ld_addr;
  logic        enr, enw, wea, ld_en, ld_sel;
  logic [15:0] ld_data, sum, rb_data;
  logic        sum_vld, ovf;
  logic [10:0] wr_cnt;

  logic [1:0]  addr2, ld_addr2;
  logic        enw2, wea2, sum_vld2, ovf2;
  logic [7:0]  sum2, rb_data2;
  logic [2:0]  wr_cnt2;

  int n_chk = 0;
  int n_bad = 0;

  always #5 gclk = ~gclk;

  vadd_mem #(.DATA_W(16), .ADDR_W(10)) dut (
    .clk(gclk), .rst(rst), .addr(addr), .enr(enr), .enw(enw), .wea(wea),
    .sum(sum), .sum_vld(sum_vld), .wr_cnt(wr_cnt), .ovf(ovf),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data), .rb_data(rb_data)
  );

  vadd_mem #(.DATA_W(8), .ADDR_W(2)) dut2 (
    .clk(gclk), .rst(rst), .addr(addr2), .enr(1'b0), .enw(enw2), .wea(wea2),
    .sum(sum2), .sum_vld(sum_vld2), .wr_cnt(wr_cnt2), .ovf(ovf2),
    .ld_en(1'b0), .ld_sel(1'b0), .ld_addr(ld_addr2), .ld_data(8'h00), .rb_data(rb_data2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are observed there too.
  task automatic step();
    @(negedge gclk);
  endtask

  task automatic load(input logic sel, input logic [9:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_sel = sel; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a);
    enr = 1'b1; addr = a;
    step();
    enr = 1'b0;
    step();
  endtask

  initial begin
    logic [15:0] exp_ovf;
    rst = 1'b1; addr = '0; enr = 0; enw = 0; wea = 0;
    ld_en = 0; ld_sel = 0; ld_addr = '0; ld_data = '0;
    addr2 = '0; ld_addr2 = '0; enw2 = 0; wea2 = 0;
    step(); step();
    chk("rst_sum", sum, 0);
    chk("rst_vld", sum_vld, 0);
    chk("rst_cnt", wr_cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_rb", rb_data, 0);
    chk("rst_cnt2", wr_cnt2, 0);
    rst = 1'b0;
    step();

    // basic add and C write/readback
    load(1'b0, 10'd3, 16'd10);
    load(1'b1, 10'd3, 16'd20);
    enr = 1'b1; addr = 10'd3;
    step();
    enr = 1'b0;
    chk("lat_vld_early", sum_vld, 0);
    step();
    chk("basic_sum", sum, 30);
    chk("basic_vld", sum_vld, 1);
    enw = 1'b1; wea = 1'b1; addr = 10'd3;
    step();
    enw = 1'b0; wea = 1'b0;
    chk("basic_vld_pulse", sum_vld, 0);
    chk("basic_cnt", wr_cnt, 1);
    ld_addr = 10'd3;
    step();
    chk("basic_rb", rb_data, 30);

    // streaming, back-to-back reads
    for (int i = 0; i < 8; i++) begin
      load(1'b0, 10'(i), 16'(i));
      load(1'b1, 10'(i), 16'(2*i));
    end
    for (int i = 0; i < 11; i++) begin
      if (i >= 2 && i < 10) begin
        chk($sformatf("strm_sum%0d", i-2), sum, 32'(3*(i-2)));
        chk($sformatf("strm_vld%0d", i-2), sum_vld, 1);
      end
      if (i == 10) chk("strm_vld_end", sum_vld, 0);
      enr = (i < 8); addr = 10'(i);
      step();
    end
    enr = 1'b0;

    // overflow
    chk("ovf_before", ovf, 0);
    load(1'b0, 10'd0, 16'hFFFF);
    load(1'b1, 10'd0, 16'd2);
    rd(10'd0);
`ifdef VADD_SAT_EN
    exp_ovf = 16'hFFFF;
`else
    exp_ovf = 16'h0001;
`endif
    chk("ovf_sum", sum, exp_ovf);
    chk("ovf_flag", ovf, 1);

    // read-first collision on host load
    load(1'b0, 10'd5, 16'd7);
    load(1'b1, 10'd5, 16'd0);
    ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 10'd5; ld_data = 16'd9;
    enr = 1'b1; addr = 10'd5;
    step();
    ld_en = 1'b0; enr = 1'b0;
    step();
    chk("coll_old", sum, 7);
    rd(10'd5);
    chk("coll_new", sum, 9);
    chk("ovf_sticky", ovf, 1);

    // C write vs readback at same address: old value first
    ld_addr = 10'd3; enw = 1'b1; wea = 1'b1; addr = 10'd3;
    step();
    enw = 1'b0; wea = 1'b0;
    chk("rbcoll_old", rb_data, 30);
    chk("rbcoll_cnt", wr_cnt, 2);
    step();
    chk("rbcoll_new", rb_data, 9);
    enw = 1'b1; wea = 1'b0;
    step();
    enw = 1'b0;
    chk("noweа_cnt", wr_cnt, 2);

    // reset with a read in flight
    enr = 1'b1; addr = 10'd5;
    step();
    enr = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_sum", sum, 0);
    chk("mrst_cnt", wr_cnt, 0);
    chk("mrst_ovf", ovf, 0);
    chk("mrst_vld", sum_vld, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mrst_novld%0d", i), sum_vld, 0);
    end

    // counter saturation on the 4-deep instance
    enw2 = 1'b1; wea2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      addr2 = 2'(i);
      step();
      chk($sformatf("sat_cnt%0d", i), wr_cnt2, (i < 3) ? 32'(i+1) : 32'd4);
    end
    enw2 = 1'b0; wea2 = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
